// File: rtl/seq1011_pkg.sv
// Shared types and constants for the "1011" stream detector controller.
package seq1011_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam logic [3:0]  PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    DONE
  } ctrl_state_t;

  typedef enum logic [2:0] {
    S0,
    S1,
    S10,
    S101,
    S1011
  } det_state_t;

endpackage

// File: rtl/seq1011_stream_ctrl_if.sv
// Valid/ready word stream into the detector controller.
interface seq1011_stream_ctrl_if #(
  parameter int unsigned WORD_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;

  modport master (output in_valid, output in_data, output in_last, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface

// File: rtl/seq1011_det.sv
// Moore "1011" detector; one bit per cycle when bit_vld, registered match.
// SEQ1011_OVERLAP_EN selects overlapped detection after a match.
module seq1011_det
  import seq1011_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_in,
  input  logic bit_vld,
  output logic match
);

  det_state_t st_q, st_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= S0;
      match <= 1'b0;
    end else if (clr) begin
      st_q  <= S0;
      match <= 1'b0;
    end else begin
      st_q  <= st_d;
      match <= bit_vld && (st_d == S1011);
    end
  end

  // Transitions advance only on a valid bit; otherwise history is held.
  always_comb begin
    st_d = st_q;
    if (bit_vld) begin
      case (st_q)
        S0:    st_d = (bit_in == PATTERN[3]) ? S1   : S0;
        S1:    st_d = (bit_in == PATTERN[2]) ? S10  : S1;
        S10:   st_d = (bit_in == PATTERN[1]) ? S101 : S0;
        S101:  st_d = (bit_in == PATTERN[0]) ? S1011 : S10;
`ifdef SEQ1011_OVERLAP_EN
        S1011: st_d = bit_in ? S1 : S10;
`else
        S1011: st_d = bit_in ? S1 : S0;
`endif
        default: st_d = S0;
      endcase
    end
  end

endmodule

// File: rtl/seq1011_stream_ctrl.sv
// Accepts words, serializes them MSB first into seq1011_det and counts matches per frame.
// Overlap behaviour is selected by SEQ1011_OVERLAP_EN in seq1011_det.
module seq1011_stream_ctrl
  import seq1011_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq1011_stream_ctrl_if.slave stream,
  output logic                 busy,
  output logic                 match_pulse,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 frame_done
);

  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  ctrl_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] data_q;
  logic              last_q;
  logic              in_frame_q;
  logic              in_ready_q;

  logic              in_ready_d, busy_d, frame_done_d;
  logic              hs_c, first_hs_c, bit_vld_c, bit_in_c;

  assign stream.in_ready = in_ready_q;
  assign hs_c            = stream.in_valid && in_ready_q;
  assign first_hs_c      = hs_c && !in_frame_q;

  // State register and registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs_c) state_d = SHIFT;
      SHIFT:   if (idx_q == '0) state_d = last_q ? FLUSH : IDLE;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d   = 1'b0;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    bit_vld_c    = 1'b0;
    bit_in_c     = 1'b0;
    in_ready_d   = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
    if (state_q == SHIFT) begin
      bit_vld_c = 1'b1;
      bit_in_c  = data_q[idx_q];
    end
  end

  // Word capture, bit index and per-frame match counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      in_frame_q <= 1'b0;
      match_cnt  <= '0;
    end else begin
      if (hs_c) begin
        data_q     <= stream.in_data;
        last_q     <= stream.in_last;
        idx_q      <= IDX_W'(WORD_W - 1);
        in_frame_q <= 1'b1;
      end else if (bit_vld_c) begin
        idx_q <= idx_q - IDX_W'(1);
      end
      if (state_q == FLUSH) begin
        in_frame_q <= 1'b0;
      end
      if (first_hs_c) begin
        match_cnt <= '0;
      end else if (match_pulse && (match_cnt != '1)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

  seq1011_det u_det (
    .clk     (clk),
    .rst     (rst),
    .clr     (first_hs_c),
    .bit_in  (bit_in_c),
    .bit_vld (bit_vld_c),
    .match   (match_pulse)
  );

endmodule

// File: tb/tb_seq1011_stream_ctrl.sv
// Self-checking bench for seq1011_stream_ctrl: vector table, directed corners, random frames vs model.
module tb_seq1011_stream_ctrl;

  localparam int unsigned WORD_W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic       match_pulse;
  logic [7:0] match_cnt;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int pulse_total = 0;
  int done_total = 0;

  seq1011_stream_ctrl_if #(.WORD_W(WORD_W)) bus ();

  seq1011_stream_ctrl #(.WORD_W(WORD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .stream      (bus),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_cnt   (match_cnt),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (match_pulse === 1'b1) pulse_total++;
      if (frame_done === 1'b1) done_total++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Count of "1011" occurrences in the serialized bit stream of a frame.
  function automatic int model_matches(input logic [7:0] w[$]);
    int n     = 0;
    int since = 4;
    int win   = 0;
    foreach (w[i]) begin
      for (int k = 7; k >= 0; k--) begin
        win = ((win << 1) | int'(w[i][k])) & 15;
        since++;
`ifdef SEQ1011_OVERLAP_EN
        if (win == 11) begin n++; since = 0; end
`else
        if (win == 11 && since >= 4) begin n++; since = 0; end
`endif
      end
    end
    return n;
  endfunction

  task automatic send_word(input logic [7:0] d, input bit l, input int gap,
                           output int low, output int done_at, output int cnt_done,
                           output int cnt1, output int busy_bad, output bit ok);
    int t;
    low = 0; done_at = 0; cnt_done = -1; busy_bad = 0; ok = 1'b1;
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) step();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin step(); t++; end
    if (bus.in_ready !== 1'b1) ok = 1'b0;
    step();
    if (l) bus.in_valid = 1'b0;
    cnt1 = int'(match_cnt);
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      low++;
      if (busy !== 1'b1) busy_bad++;
      if (frame_done === 1'b1 && done_at == 0) begin
        done_at  = low;
        cnt_done = int'(match_cnt);
      end
      step();
      t++;
    end
    if (bus.in_ready !== 1'b1) ok = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [7:0] w[$], input int exp_raw, input int gap_max);
    int p0, d0, low, done_at, cnt_done, cnt1, busy_bad;
    int timeouts, bad_low, bad_busy, exp_cnt;
    bit ok, l;
    exp_cnt  = (exp_raw > 255) ? 255 : exp_raw;
    p0 = pulse_total; d0 = done_total;
    timeouts = 0; bad_low = 0; bad_busy = 0; done_at = 0; cnt_done = -1;
    for (int i = 0; i < w.size(); i++) begin
      l = (i == w.size() - 1);
      send_word(w[i], l, int'($urandom_range(0, gap_max)), low, done_at, cnt_done, cnt1, busy_bad, ok);
      if (!ok) timeouts++;
      if (i == 0) check({name, "_clr_on_first"}, cnt1, 0);
      if (low != (l ? WORD_W + 2 : WORD_W)) bad_low++;
      bad_busy += busy_bad;
    end
    check({name, "_timeouts"}, timeouts, 0);
    check({name, "_ready_low"}, bad_low, 0);
    check({name, "_busy"}, bad_busy, 0);
    check({name, "_done_cycle"}, done_at, WORD_W + 2);
    check({name, "_cnt_at_done"}, cnt_done, exp_cnt);
    check({name, "_pulses"}, pulse_total - p0, exp_raw);
    check({name, "_done_count"}, done_total - d0, 1);
    repeat (3) step();
    check({name, "_cnt_hold"}, match_cnt, exp_cnt);
  endtask

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    int         nwords;
    int         exp_ovl;
    int         exp_novl;
  } vec_t;

  initial begin
    vec_t       vecs [9];
    logic [7:0] q[$];
    int         exp, to, d0, nw;

    vecs[0] = '{8'hB0, 8'h00, 1, 1, 1};
    vecs[1] = '{8'hB6, 8'h00, 1, 2, 1};
    vecs[2] = '{8'h02, 8'hC0, 2, 1, 1};
    vecs[3] = '{8'h0B, 8'h00, 1, 1, 1};
    vecs[4] = '{8'hFF, 8'h00, 1, 0, 0};
    vecs[5] = '{8'h00, 8'h00, 2, 0, 0};
    vecs[6] = '{8'hBB, 8'h00, 1, 2, 2};
    vecs[7] = '{8'h2D, 8'hA0, 2, 2, 1};
    vecs[8] = '{8'h01, 8'h60, 2, 1, 1};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) step();
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_match_pulse", match_pulse, 0);
    check("reset_match_cnt", match_cnt, 0);
    check("reset_frame_done", frame_done, 0);
    rst = 1'b0;
    step();
    check("post_reset_in_ready", bus.in_ready, 1);
    check("post_reset_busy", busy, 0);

    for (int i = 0; i < 9; i++) begin
      q = {};
      q.push_back(vecs[i].w0);
      if (vecs[i].nwords > 1) q.push_back(vecs[i].w1);
`ifdef SEQ1011_OVERLAP_EN
      exp = vecs[i].exp_ovl;
`else
      exp = vecs[i].exp_novl;
`endif
      run_frame($sformatf("vec%0d", i), q, exp, 2);
    end

    q = {};
    repeat (200) q.push_back(8'hBB);
    run_frame("sat", q, 400, 0);
    q = {};
    q.push_back(8'h0B);
    run_frame("after_sat", q, 1, 0);

    for (int f = 0; f < 25; f++) begin
      q  = {};
      nw = int'($urandom_range(1, 4));
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 2) == 0) q.push_back(8'hB6 ^ 8'($urandom_range(0, 3)));
        else q.push_back(8'($urandom));
      end
      run_frame($sformatf("rand%0d", f), q, model_matches(q), 3);
    end

    // Reset in the 4th shift cycle of a last word abandons the frame.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_last  = 1'b1;
    to = 0;
    while (bus.in_ready !== 1'b1 && to < 50) begin step(); to++; end
    check("rst_mid_hs_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    check("rst_mid_busy_before", busy, 1);
    d0 = done_total;
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", bus.in_ready, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_match_pulse", match_pulse, 0);
    check("rst_mid_match_cnt", match_cnt, 0);
    check("rst_mid_frame_done", frame_done, 0);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_mid_ready_after", bus.in_ready, 1);
    check("rst_mid_busy_after", busy, 0);
    repeat (4) step();
    check("rst_mid_no_done", done_total - d0, 0);
    q = {};
    q.push_back(8'h0B);
    run_frame("post_rst", q, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
